// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and access sequencer for a
// single-ported data memory. Port 0 is the processor load/store path,
// port 1 is the debug/DMA path. One request is accepted at a time; each
// grant produces exactly one single-cycle memory access. For reads, the
// data comes back through a registered rvalid/rdata pair on the owning port.
//
// Handshake: a requester raises pN_req together with stable we/addr/wdata.
// It holds them until it sees pN_gnt, a one-cycle pulse issued in the
// ACCESS cycle. The requester must drop req in the cycle after gnt if it
// has nothing more to do, because a req still high in that IDLE cycle is
// taken as a fresh request. Read data is presented on pN_rdata with a
// one-cycle pN_rvalid pulse. pN_rdata then holds until the next read
// completes on the same port.
module dmem_arbiter #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_gnt,
  output logic              p0_rvalid,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_gnt,
  output logic              p1_rvalid,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_write_data,
  output logic              mem_write_enable,
  output logic              mem_read_enable,
  input  logic [DATA_W-1:0] mem_read_data,

  output logic              busy,
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_e;

  state_e              state_q, state_d;

  // Round-robin pointer: the port granted most recently (1 after reset so
  // that port 0 wins the first tie).
  logic                last_q, last_d;
  // Port that owns the access currently in flight.
  logic                owner_q, owner_d;

  // Command registers holding the winner's controls for the whole access.
  logic                cmd_we_q, cmd_we_d;
  logic [ADDR_W-1:0]   cmd_addr_q, cmd_addr_d;
  logic [DATA_W-1:0]   cmd_wdata_q, cmd_wdata_d;

  // Registered output strobes.
  logic                gnt0_q, gnt0_d;
  logic                gnt1_q, gnt1_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                rvalid0_q, rvalid0_d;
  logic                rvalid1_q, rvalid1_d;
  logic                busy_q, busy_d;

  // Per-port read result registers.
  logic [DATA_W-1:0]   rdata0_q, rdata0_d;
  logic [DATA_W-1:0]   rdata1_q, rdata1_d;

  // Arbitration decision, only meaningful while in IDLE.
  logic                any_req;
  logic                winner;

  // Pick the winner: a lone requester always wins, a tie goes to the port
  // that was not granted last.
  always_comb begin
    any_req = p0_req | p1_req;
    winner  = 1'b0;
    if (p0_req && p1_req) begin
      winner = ~last_q;
    end else if (p1_req) begin
      winner = 1'b1;
    end else begin
      winner = 1'b0;
    end
  end

  // Next-state and next-output logic for the IDLE/ACCESS/RDATA sequencer.
  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    owner_d     = owner_q;
    cmd_we_d    = cmd_we_q;
    cmd_addr_d  = cmd_addr_q;
    cmd_wdata_d = cmd_wdata_q;
    gnt0_d      = 1'b0;
    gnt1_d      = 1'b0;
    mem_we_d    = 1'b0;
    mem_re_d    = 1'b0;
    rvalid0_d   = 1'b0;
    rvalid1_d   = 1'b0;
    rdata0_d    = rdata0_q;
    rdata1_d    = rdata1_q;

    unique case (state_q)
      IDLE: begin
        if (any_req) begin
          state_d = ACCESS;
          last_d  = winner;
          owner_d = winner;
          if (winner) begin
            cmd_we_d    = p1_we;
            cmd_addr_d  = p1_addr;
            cmd_wdata_d = p1_wdata;
          end else begin
            cmd_we_d    = p0_we;
            cmd_addr_d  = p0_addr;
            cmd_wdata_d = p0_wdata;
          end
          // Strobes for the ACCESS cycle are registered here so that they
          // appear exactly during ACCESS and nowhere else.
          gnt0_d   = ~winner;
          gnt1_d   = winner;
          mem_we_d = cmd_we_d;
          mem_re_d = ~cmd_we_d;
        end
      end

      ACCESS: begin
        // A write completes at the closing edge of ACCESS; a read still
        // needs the memory's one-cycle read latency.
        if (cmd_we_q) begin
          state_d = IDLE;
        end else begin
          state_d = RDATA;
        end
      end

      RDATA: begin
        // Memory read data is valid now; capture it for the owner only.
        state_d = IDLE;
        if (owner_q) begin
          rdata1_d  = mem_read_data;
          rvalid1_d = 1'b1;
        end else begin
          rdata0_d  = mem_read_data;
          rvalid0_d = 1'b1;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State, command and output registers; asynchronous reset clears all of
  // them so an access in flight is abandoned immediately.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      last_q      <= 1'b1;
      owner_q     <= 1'b0;
      cmd_we_q    <= 1'b0;
      cmd_addr_q  <= '0;
      cmd_wdata_q <= '0;
      gnt0_q      <= 1'b0;
      gnt1_q      <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_re_q    <= 1'b0;
      rvalid0_q   <= 1'b0;
      rvalid1_q   <= 1'b0;
      rdata0_q    <= '0;
      rdata1_q    <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      last_q      <= last_d;
      owner_q     <= owner_d;
      cmd_we_q    <= cmd_we_d;
      cmd_addr_q  <= cmd_addr_d;
      cmd_wdata_q <= cmd_wdata_d;
      gnt0_q      <= gnt0_d;
      gnt1_q      <= gnt1_d;
      mem_we_q    <= mem_we_d;
      mem_re_q    <= mem_re_d;
      rvalid0_q   <= rvalid0_d;
      rvalid1_q   <= rvalid1_d;
      rdata0_q    <= rdata0_d;
      rdata1_q    <= rdata1_d;
      busy_q      <= busy_d;
    end
  end

  // Address and write data come straight from the command registers.
  assign mem_address      = cmd_addr_q;
  assign mem_write_data   = cmd_wdata_q;
  assign mem_write_enable = mem_we_q;
  assign mem_read_enable  = mem_re_q;

  assign p0_gnt    = gnt0_q;
  assign p1_gnt    = gnt1_q;
  assign p0_rvalid = rvalid0_q;
  assign p1_rvalid = rvalid1_q;
  assign p0_rdata  = rdata0_q;
  assign p1_rdata  = rdata1_q;
  assign busy      = busy_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed testbench for dmem_arbiter with a behavioural data_memory model.
module tb_dmem_arbiter;

  localparam int ADDR_W = 4;
  localparam int DATA_W = 16;

  logic              clk;
  logic              rst_n;
  logic              p0_req, p0_we, p1_req, p1_we;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [DATA_W-1:0] p0_wdata, p1_wdata;
  logic              p0_gnt, p1_gnt, p0_rvalid, p1_rvalid;
  logic [DATA_W-1:0] p0_rdata, p1_rdata;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_write_data;
  logic              mem_write_enable, mem_read_enable;
  logic [DATA_W-1:0] mem_read_data;
  logic              busy;
  logic [1:0]        dbg_state;

  int checks = 0;
  int failures = 0;

  // Event counters, sampled at each rising edge (values of the cycle just ended).
  int n_p0_gnt = 0, n_p1_gnt = 0, n_p0_rv = 0, n_p1_rv = 0;
  int n_we = 0, n_re = 0, n_both_en = 0, n_en_outside = 0;

  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] mem_model [16];

  dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
    .mem_address(mem_address), .mem_write_data(mem_write_data),
    .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
    .mem_read_data(mem_read_data), .busy(busy), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- data_memory model ----------------
  initial begin
    for (int i = 0; i < 16; i++) mem_model[i] = '0;
    mem_read_data = '0;
  end

  always @(posedge clk) begin
    if (mem_write_enable) mem_model[mem_address] <= mem_write_data;
    if (mem_read_enable) mem_read_data <= mem_model[mem_address];
  end

  // ---------------- monitor ----------------
  always @(posedge clk) begin
    if (p0_gnt) n_p0_gnt++;
    if (p1_gnt) n_p1_gnt++;
    if (p0_rvalid) n_p0_rv++;
    if (p1_rvalid) n_p1_rv++;
    if (mem_write_enable) n_we++;
    if (mem_read_enable) n_re++;
    if (mem_write_enable && mem_read_enable) n_both_en++;
    if ((mem_write_enable || mem_read_enable) && dbg_state != 2'd1) n_en_outside++;
  end

  // ---------------- driver tasks ----------------
  task automatic step();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    p0_req = 0; p0_we = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_we = 0; p1_addr = '0; p1_wdata = '0;
  endtask

  task automatic drive_p0(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    p0_req = 1; p0_we = we; p0_addr = a; p0_wdata = d;
  endtask

  task automatic drive_p1(input logic we, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    p1_req = 1; p1_we = we; p1_addr = a; p1_wdata = d;
  endtask

  task automatic do_reset();
    step();
    idle_inputs();
    rst_n = 0;
    repeat (2) step();
    rst_n = 1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 0;
    idle_inputs();
    #3;
    checks++; if ({p0_gnt, p1_gnt, p0_rvalid, p1_rvalid} !== 4'b0) begin failures++; $display("FAIL reset_strobes: got %b expected 0000", {p0_gnt, p1_gnt, p0_rvalid, p1_rvalid}); end
    checks++; if ({mem_write_enable, mem_read_enable, busy} !== 3'b0) begin failures++; $display("FAIL reset_mem_en_busy: got %b expected 000", {mem_write_enable, mem_read_enable, busy}); end
    checks++; if ({p0_rdata, p1_rdata} !== 32'h0) begin failures++; $display("FAIL reset_rdata: got %h expected 0", {p0_rdata, p1_rdata}); end
    checks++; if ({mem_address, mem_write_data} !== 20'h0) begin failures++; $display("FAIL reset_mem_bus: got %h expected 0", {mem_address, mem_write_data}); end
    checks++; if (dbg_state !== 2'd0) begin failures++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    repeat (2) step();
    rst_n = 1;
  endtask

  task automatic test_write_read_p0();
    int g0, w0, rv1;
    step();
    g0 = n_p0_gnt; w0 = n_we; rv1 = n_p1_rv;
    drive_p0(1, 4'd0, 16'hA5A5);
    step();
    checks++; if ({p0_gnt, p1_gnt, mem_write_enable, mem_read_enable, busy} !== 5'b10101) begin failures++; $display("FAIL wr_access_strobes: got %b expected 10101", {p0_gnt, p1_gnt, mem_write_enable, mem_read_enable, busy}); end
    checks++; if ({mem_address, mem_write_data} !== {4'd0, 16'hA5A5}) begin failures++; $display("FAIL wr_access_bus: got %h expected 0a5a5", {mem_address, mem_write_data}); end
    p0_req = 0;
    step();
    checks++; if ({p0_gnt, mem_write_enable, busy} !== 3'b000) begin failures++; $display("FAIL wr_after: got %b expected 000", {p0_gnt, mem_write_enable, busy}); end
    drive_p0(0, 4'd0, 16'h0000);
    step();
    checks++; if ({p0_gnt, mem_write_enable, mem_read_enable, mem_address} !== {3'b101, 4'd0}) begin failures++; $display("FAIL rd_access: got %b expected 1010000", {p0_gnt, mem_write_enable, mem_read_enable, mem_address}); end
    p0_req = 0;
    step();
    checks++; if ({p0_rvalid, mem_read_enable, busy} !== 3'b001) begin failures++; $display("FAIL rd_rdata_cycle: got %b expected 001", {p0_rvalid, mem_read_enable, busy}); end
    step();
    checks++; if ({p0_rvalid, busy} !== 2'b10) begin failures++; $display("FAIL rd_rvalid: got %b expected 10", {p0_rvalid, busy}); end
    checks++; if (p0_rdata !== 16'hA5A5) begin failures++; $display("FAIL rd_rdata: got %h expected a5a5", p0_rdata); end
    step();
    checks++; if (p0_rvalid !== 1'b0) begin failures++; $display("FAIL rd_rvalid_pulse: got %b expected 0", p0_rvalid); end
    checks++; if ((n_p0_gnt - g0) != 2) begin failures++; $display("FAIL wr_rd_gnt_count: got %0d expected 2", n_p0_gnt - g0); end
    checks++; if ((n_we - w0) != 1) begin failures++; $display("FAIL wr_we_count: got %0d expected 1", n_we - w0); end
    checks++; if ((n_p1_rv - rv1) != 0) begin failures++; $display("FAIL wr_rd_p1_rvalid: got %0d expected 0", n_p1_rv - rv1); end
  endtask

  task automatic test_simultaneous_writes();
    do_reset();
    drive_p0(1, 4'd5, 16'h1234);
    drive_p1(1, 4'd5, 16'h5678);
    step();
    checks++; if ({p0_gnt, p1_gnt, mem_write_enable} !== 3'b101) begin failures++; $display("FAIL sim_first_gnt: got %b expected 101", {p0_gnt, p1_gnt, mem_write_enable}); end
    checks++; if ({mem_address, mem_write_data} !== {4'd5, 16'h1234}) begin failures++; $display("FAIL sim_first_bus: got %h expected 51234", {mem_address, mem_write_data}); end
    p0_req = 0;
    step();
    checks++; if ({p0_gnt, p1_gnt, busy} !== 3'b000) begin failures++; $display("FAIL sim_gap: got %b expected 000", {p0_gnt, p1_gnt, busy}); end
    step();
    checks++; if ({p0_gnt, p1_gnt, mem_write_enable} !== 3'b011) begin failures++; $display("FAIL sim_second_gnt: got %b expected 011", {p0_gnt, p1_gnt, mem_write_enable}); end
    checks++; if ({mem_address, mem_write_data} !== {4'd5, 16'h5678}) begin failures++; $display("FAIL sim_second_bus: got %h expected 55678", {mem_address, mem_write_data}); end
    p1_req = 0;
    step();
    drive_p0(0, 4'd5, 16'h0);
    step();
    p0_req = 0;
    repeat (2) step();
    checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, 16'h5678}) begin failures++; $display("FAIL sim_readback: got %h expected 15678", {p0_rvalid, p0_rdata}); end
  endtask

  task automatic test_contention();
    int both0, re0, outside0;
    logic [1:0] exp_gnt, exp_rv;
    logic [DATA_W-1:0] exp_d;
    do_reset();
    both0 = n_both_en; re0 = n_re; outside0 = n_en_outside;
    drive_p0(0, 4'd0, 16'h0);
    drive_p1(0, 4'd5, 16'h0);
    for (int k = 1; k <= 12; k++) begin
      step();
      exp_gnt = 2'b00; exp_rv = 2'b00;
      if ((k - 1) % 3 == 0) begin
        exp_gnt = (((k - 1) / 3) % 2 == 0) ? 2'b10 : 2'b01;
        exp_q.push_back((((k - 1) / 3) % 2 == 0) ? 16'hA5A5 : 16'h5678);
      end
      if ((k - 1) % 3 == 2) exp_rv = (((k - 1) / 3) % 2 == 0) ? 2'b10 : 2'b01;
      checks++; if ({p0_gnt, p1_gnt} !== exp_gnt) begin failures++; $display("FAIL cont_gnt k=%0d: got %b expected %b", k, {p0_gnt, p1_gnt}, exp_gnt); end
      checks++; if ({p0_rvalid, p1_rvalid} !== exp_rv) begin failures++; $display("FAIL cont_rvalid k=%0d: got %b expected %b", k, {p0_rvalid, p1_rvalid}, exp_rv); end
      if (exp_rv != 2'b00 && exp_q.size() > 0) begin
        exp_d = exp_q.pop_front();
        checks++;
        if ((exp_rv[1] ? p0_rdata : p1_rdata) !== exp_d) begin
          failures++; $display("FAIL cont_rdata k=%0d: got %h expected %h", k, exp_rv[1] ? p0_rdata : p1_rdata, exp_d);
        end
      end
      if (k == 12) idle_inputs();
    end
    step();
    checks++; if ({p0_gnt, p1_gnt, busy} !== 3'b000) begin failures++; $display("FAIL cont_drain: got %b expected 000", {p0_gnt, p1_gnt, busy}); end
    checks++; if ((n_re - re0) != 4) begin failures++; $display("FAIL cont_re_count: got %0d expected 4", n_re - re0); end
    checks++; if ((n_both_en - both0) != 0) begin failures++; $display("FAIL cont_both_en: got %0d expected 0", n_both_en - both0); end
    checks++; if ((n_en_outside - outside0) != 0) begin failures++; $display("FAIL cont_en_outside: got %0d expected 0", n_en_outside - outside0); end
  endtask

  task automatic test_p1_isolation();
    int rv0;
    rv0 = n_p0_rv;
    // Read address 0 on port 1 first so the following read visibly changes p1_rdata.
    drive_p1(0, 4'd0, 16'h0);
    step();
    p1_req = 0;
    repeat (2) step();
    checks++; if ({p1_rvalid, p1_rdata} !== {1'b1, 16'hA5A5}) begin failures++; $display("FAIL iso_p1_first: got %h expected 1a5a5", {p1_rvalid, p1_rdata}); end
    drive_p1(0, 4'd5, 16'h0);
    step();
    checks++; if ({p0_gnt, p1_gnt, mem_address} !== {2'b01, 4'd5}) begin failures++; $display("FAIL iso_gnt: got %b expected 010101", {p0_gnt, p1_gnt, mem_address}); end
    p1_req = 0;
    repeat (2) step();
    checks++; if ({p1_rvalid, p1_rdata} !== {1'b1, 16'h5678}) begin failures++; $display("FAIL iso_p1_rdata: got %h expected 15678", {p1_rvalid, p1_rdata}); end
    checks++; if (p0_rdata !== 16'hA5A5) begin failures++; $display("FAIL iso_p0_hold: got %h expected a5a5", p0_rdata); end
    checks++; if ((n_p0_rv - rv0) != 0) begin failures++; $display("FAIL iso_p0_rvalid: got %0d expected 0", n_p0_rv - rv0); end
    step();
  endtask

  task automatic test_reset_during_write();
    int g;
    drive_p0(1, 4'd0, 16'hFFFF);
    step();
    checks++; if ({p0_gnt, mem_write_enable} !== 2'b11) begin failures++; $display("FAIL rstw_in_access: got %b expected 11", {p0_gnt, mem_write_enable}); end
    p0_req = 0;
    #2 rst_n = 0;
    #1;
    checks++; if ({p0_gnt, p1_gnt, mem_write_enable, mem_read_enable, busy, p0_rvalid, p1_rvalid} !== 7'b0) begin failures++; $display("FAIL rstw_async_strobes: got %b expected 0", {p0_gnt, p1_gnt, mem_write_enable, mem_read_enable, busy, p0_rvalid, p1_rvalid}); end
    checks++; if ({mem_address, mem_write_data, p0_rdata, p1_rdata} !== 52'h0) begin failures++; $display("FAIL rstw_async_data: got %h expected 0", {mem_address, mem_write_data, p0_rdata, p1_rdata}); end
    #1 rst_n = 1;
    g = n_p0_gnt + n_p1_gnt;
    repeat (3) step();
    checks++; if ((n_p0_gnt + n_p1_gnt - g) != 0 || busy !== 1'b0) begin failures++; $display("FAIL rstw_no_gnt: got %0d grants busy=%b expected 0 grants busy=0", n_p0_gnt + n_p1_gnt - g, busy); end
    drive_p0(0, 4'd0, 16'h0);
    step();
    p0_req = 0;
    repeat (2) step();
    checks++; if ({p0_rvalid, p0_rdata} !== {1'b1, 16'hA5A5}) begin failures++; $display("FAIL rstw_readback: got %h expected 1a5a5", {p0_rvalid, p0_rdata}); end
    step();
  endtask

  task automatic test_back_to_back();
    drive_p0(0, 4'd0, 16'h0);
    step();
    p0_req = 0;
    step();
    checks++; if (dbg_state !== 2'd2) begin failures++; $display("FAIL b2b_in_rdata: got %0d expected 2", dbg_state); end
    drive_p1(0, 4'd5, 16'h0);
    step();
    checks++; if ({p0_rvalid, p0_rdata, p1_gnt, busy} !== {1'b1, 16'hA5A5, 2'b00}) begin failures++; $display("FAIL b2b_rvalid_idle: got %h expected 1a5a5 with gnt/busy 0", {p0_rvalid, p0_rdata, p1_gnt, busy}); end
    step();
    checks++; if ({p1_gnt, p0_gnt, mem_read_enable, mem_address} !== {3'b101, 4'd5}) begin failures++; $display("FAIL b2b_p1_gnt: got %b expected 1010101", {p1_gnt, p0_gnt, mem_read_enable, mem_address}); end
    p1_req = 0;
    repeat (2) step();
    checks++; if ({p1_rvalid, p1_rdata} !== {1'b1, 16'h5678}) begin failures++; $display("FAIL b2b_p1_rdata: got %h expected 15678", {p1_rvalid, p1_rdata}); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_write_read_p0();
    test_simultaneous_writes();
    test_contention();
    test_p1_isolation();
    test_reset_during_write();
    test_back_to_back();
    repeat (2) step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
